// File: rtl/uart_core.sv
// uart_core: full-duplex UART with one TX engine and one RX engine on a
// shared clock. Frame format, bit period, parity and stop bits are set by
// parameters. RX has a one-entry holding register with overrun reporting and
// can be fed internally from the TX bitstream (loopback).
//
// Both engines use the same state encoding:
//   state    | meaning
//   S_IDLE   | line idle; TX waits for tx_valid, RX waits for a falling edge
//   S_START  | start bit; RX resamples it at mid-bit to reject glitches
//   S_DATA   | DATA_BITS payload bits, LSB first
//   S_PARITY | optional parity bit (never entered when PARITY == 0)
//   S_STOP   | STOP_BITS stop bits; TX can accept new data in the last cycle
module uart_core #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 loopback
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic            PAR_EN    = (PARITY != 0);
  localparam logic            PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t                 tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [3:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_line_q, tx_line_d;
  logic                   tx_last;
  logic                   tx_accept;

  assign tx_last   = (tx_state_q == S_STOP) && (tx_cnt_q == '0) && (tx_bit_q == LAST_STOP);
  assign tx_ready  = (tx_state_q == S_IDLE) || tx_last;
  assign tx_accept = tx_valid && tx_ready;
  assign tx        = loopback ? 1'b1 : tx_line_q;

  // TX next state: bit-period down-counter, bit index, shift register; the
  // serial line is registered from the next state so the pin never glitches.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = 1'b1;
    case (tx_state_q)
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = CNT_FULL;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == LAST_DATA) begin
            tx_state_d = PAR_EN ? S_PARITY : S_STOP;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          if (tx_bit_q == LAST_STOP) begin
            tx_state_d = S_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_cnt_d = CNT_FULL;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    // An accept in the final stop cycle overrides the return to idle, giving
    // contiguous back-to-back frames.
    if (tx_accept) begin
      tx_state_d = S_START;
      tx_cnt_d   = CNT_FULL;
      tx_bit_d   = '0;
      tx_shift_d = tx_data;
      tx_par_d   = (^tx_data) ^ PAR_ODD;
    end
    case (tx_state_d)
      S_START:  tx_line_d = 1'b0;
      S_DATA:   tx_line_d = tx_shift_d[0];
      S_PARITY: tx_line_d = tx_par_d;
      default:  tx_line_d = 1'b1;
    endcase
  end

  // TX registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // ---------------------------------------------------------------- RX
  logic                   rx_in;
  logic                   sync1_q, sync2_q, prev_q;
  state_t                 rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [3:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   perr_w_q, perr_w_d;
  logic                   ferr_w_q, ferr_w_d;
  logic                   rx_done;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_ovr_q, rx_ovr_d;

  assign rx_in         = loopback ? tx_line_q : rx;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // Requiring a high-to-low edge also keeps RX idle after a break until the
  // line has been seen high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // RX next state: mid-bit sampling with the same down-counter scheme as TX.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    perr_w_d   = perr_w_q;
    ferr_w_d   = ferr_w_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (sync2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_cnt_d   = CNT_FULL;
            rx_bit_d   = '0;
            perr_w_d   = 1'b0;
            ferr_w_d   = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_cnt_d   = CNT_FULL;
          if (rx_bit_q == LAST_DATA) begin
            rx_state_d = PAR_EN ? S_PARITY : S_STOP;
            rx_bit_d   = '0;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_PARITY: begin
        if (rx_cnt_q == '0) begin
          perr_w_d   = sync2_q ^ (^rx_shift_q) ^ PAR_ODD;
          rx_state_d = S_STOP;
          rx_cnt_d   = CNT_FULL;
          rx_bit_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          if (!sync2_q) ferr_w_d = 1'b1;
          if (rx_bit_q == LAST_STOP) begin
            rx_done    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
            rx_cnt_d = CNT_FULL;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Holding register: load when empty or being drained this cycle, else flag
  // overrun and keep the held frame untouched.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_done && rx_valid_q && !rx_ready;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (rx_done && (!rx_valid_q || rx_ready)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_shift_q;
      rx_perr_d  = perr_w_q;
      rx_ferr_d  = ferr_w_d;
    end
  end

  // RX registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      perr_w_q   <= 1'b0;
      ferr_w_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      perr_w_q   <= perr_w_d;
      ferr_w_q   <= ferr_w_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Testbench for uart_core: three instances (8N1 loopback, 8E2 on a wire or
// driven directly, 8O1 on a wire). Received frames are checked against a
// scoreboard queue filled when stimulus is driven.
module tb_uart_core;
  localparam int C = 16;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop_low;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: 8N1, loopback
  logic [7:0] a_tx_data, a_rx_data;
  logic a_tx_valid, a_tx_ready, a_tx, a_rx, a_rx_valid, a_rx_ready;
  logic a_perr, a_ferr, a_ovr, a_lb;
  // instance B: 8E2
  logic [7:0] b_tx_data, b_rx_data;
  logic b_tx_valid, b_tx_ready, b_tx, b_rx, b_rx_valid, b_rx_ready;
  logic b_perr, b_ferr, b_ovr, b_lb, b_use_wire, b_rx_drv;
  // instance C: 8O1
  logic [7:0] c_tx_data, c_rx_data;
  logic c_tx_valid, c_tx_ready, c_tx, c_rx, c_rx_valid, c_rx_ready;
  logic c_perr, c_ferr, c_ovr, c_lb;

  assign a_rx = 1'b1;
  assign b_rx = b_use_wire ? b_tx : b_rx_drv;
  assign c_rx = c_tx;

  uart_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overrun(a_ovr), .loopback(a_lb));

  uart_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx(b_tx), .rx(b_rx), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_overrun(b_ovr), .loopback(b_lb));

  uart_core #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .tx(c_tx), .rx(c_rx), .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .rx_parity_err(c_perr), .rx_frame_err(c_ferr), .rx_overrun(c_ovr), .loopback(c_lb));

  frame_t q_a[$], q_b[$], q_c[$];
  int a_rx_cnt = 0, b_rx_cnt = 0, c_rx_cnt = 0, b_ovr_cnt = 0, a_tx_bad = 0;
  vec_t tv_a[4];
  vec_t tv_b[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic par_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  task automatic push_exp(input int which, input logic [7:0] d, input logic pe, input logic fe);
    frame_t f;
    f.data = d; f.perr = pe; f.ferr = fe;
    if (which == 0) q_a.push_back(f);
    else if (which == 1) q_b.push_back(f);
    else q_c.push_back(f);
  endtask

  task automatic unexpected(input string who, input logic [7:0] d);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_frame: got data 0x%0h, expected no frame", who, d);
  endtask

  // one bit on B's rx pin, entered and left at posedge+1
  task automatic drive_bit(input logic v);
    b_rx_drv = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic pflip, input logic stop_low);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_bit(d, 1'b0) ^ pflip);
    drive_bit(!stop_low);
    drive_bit(1'b1);
  endtask

  task automatic wait_drain(input int bound);
    for (int n = 0; n < bound && (q_a.size() + q_b.size() + q_c.size()) != 0; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int   idx, base_rx, base_ovr, b_len, c_len;
  int   acc[4];
  logic rdy, b_pb, c_pb;

  initial begin
    checks = 0;
    errors = 0;
    tv_a[0] = '{8'hAB, 1'b0, 1'b0, 1'b0, 1'b0};
    tv_a[1] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tv_a[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tv_a[3] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b0};
    tv_b[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0};
    tv_b[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tv_b[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tv_b[3] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    tv_b[4] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b1; a_lb = 1'b1;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b1; b_lb = 1'b0;
    b_use_wire = 1'b1; b_rx_drv = 1'b1;
    c_tx_data = '0; c_tx_valid = 1'b0; c_rx_ready = 1'b1; c_lb = 1'b0;

    fork
      begin : monitor
        frame_t f;
        forever begin
          @(negedge clk);
          if (b_ovr === 1'b1) b_ovr_cnt++;
          if (a_tx !== 1'b1) a_tx_bad++;
          if (a_rx_valid && a_rx_ready) begin
            a_rx_cnt++;
            if (q_a.size() == 0) unexpected("a", a_rx_data);
            else begin
              f = q_a.pop_front();
              check("a_rx_data", a_rx_data, f.data);
              check("a_parity_err", a_perr, f.perr);
              check("a_frame_err", a_ferr, f.ferr);
            end
          end
          if (b_rx_valid && b_rx_ready) begin
            b_rx_cnt++;
            if (q_b.size() == 0) unexpected("b", b_rx_data);
            else begin
              f = q_b.pop_front();
              check("b_rx_data", b_rx_data, f.data);
              check("b_parity_err", b_perr, f.perr);
              check("b_frame_err", b_ferr, f.ferr);
            end
          end
          if (c_rx_valid && c_rx_ready) begin
            c_rx_cnt++;
            if (q_c.size() == 0) unexpected("c", c_rx_data);
            else begin
              f = q_c.pop_front();
              check("c_rx_data", c_rx_data, f.data);
              check("c_parity_err", c_perr, f.perr);
              check("c_frame_err", c_ferr, f.ferr);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_b_tx", b_tx, 1'b1);
    check("rst_b_tx_ready", b_tx_ready, 1'b1);
    check("rst_b_rx_valid", b_rx_valid, 1'b0);
    check("rst_b_rx_data", b_rx_data, 8'h00);
    check("rst_b_errs", {b_perr, b_ferr, b_ovr}, 3'b000);
    check("rst_c_tx", c_tx, 1'b1);
    check("rst_a_tx_ready", a_tx_ready, 1'b1);
    check("rst_a_rx_valid", a_rx_valid, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // A: back-to-back loopback frames with tx_valid held high
    idx = 0;
    a_tx_data = tv_a[0].data;
    a_tx_valid = 1'b1;
    for (int n = 0; n < 2000 && idx < 4; n++) begin
      @(negedge clk);
      rdy = a_tx_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc[idx] = cyc;
        push_exp(0, tv_a[idx].data, tv_a[idx].exp_perr, tv_a[idx].exp_ferr);
        idx++;
        if (idx < 4) a_tx_data = tv_a[idx].data;
      end
    end
    a_tx_valid = 1'b0;
    check("a_accepts", idx, 4);
    for (int i = 1; i < 4; i++) check("a_frame_spacing", acc[i] - acc[i-1], (1 + 8 + 1) * C);
    wait_drain(400);
    check("a_rx_count", a_rx_cnt, 4);
    check("a_tx_pin_high", a_tx_bad, 0);

    // B (8E2) and C (8O1) over a wire: parity bit on the line and frame length
    b_tx_data = 8'h5A; c_tx_data = 8'h5A;
    b_tx_valid = 1'b1; c_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    b_tx_valid = 1'b0; c_tx_valid = 1'b0;
    push_exp(1, 8'h5A, 1'b0, 1'b0);
    push_exp(2, 8'h5A, 1'b0, 1'b0);
    b_len = 0; c_len = 0; b_pb = 1'bx; c_pb = 1'bx;
    for (int i = 0; i < 300; i++) begin
      if (i == 9 * C + C / 2) begin b_pb = b_tx; c_pb = c_tx; end
      if (b_len == 0 && b_tx_ready) b_len = i + 1;
      if (c_len == 0 && c_tx_ready) c_len = i + 1;
      @(posedge clk);
      #1;
    end
    check("b_frame_len", b_len, (1 + 8 + 1 + 2) * C);
    check("c_frame_len", c_len, (1 + 8 + 1 + 1) * C);
    check("b_even_parity_bit", b_pb, par_bit(8'h5A, 1'b0));
    check("c_odd_parity_bit", c_pb, par_bit(8'h5A, 1'b1));
    wait_drain(200);
    check("bc_wire_rx_count", b_rx_cnt + c_rx_cnt, 2);

    // B: table of directly driven frames (parity and stop-bit faults)
    b_use_wire = 1'b0;
    base_rx = b_rx_cnt;
    for (int i = 0; i < 5; i++) begin
      push_exp(1, tv_b[i].data, tv_b[i].exp_perr, tv_b[i].exp_ferr);
      drive_frame(tv_b[i].data, tv_b[i].pflip, tv_b[i].stop_low);
    end
    drive_bit(1'b1);
    wait_drain(200);
    check("b_table_rx_count", b_rx_cnt - base_rx, 5);

    // overrun: hold rx_ready low across two frames
    base_rx = b_rx_cnt;
    base_ovr = b_ovr_cnt;
    b_rx_ready = 1'b0;
    push_exp(1, 8'h11, 1'b0, 1'b0);
    drive_frame(8'h11, 1'b0, 1'b0);
    drive_frame(8'h22, 1'b0, 1'b0);
    drive_bit(1'b1);
    check("ovr_pulse_cycles", b_ovr_cnt - base_ovr, 1);
    check("ovr_held_data", b_rx_data, 8'h11);
    check("ovr_valid_held", b_rx_valid, 1'b1);
    b_rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_fall", b_rx_valid, 1'b0);
    repeat (2 * C) @(posedge clk);
    #1;
    check("ovr_rx_count", b_rx_cnt - base_rx, 1);

    // glitch shorter than half a bit
    base_rx = b_rx_cnt;
    b_rx_drv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    b_rx_drv = 1'b1;
    repeat (3 * C) @(posedge clk);
    #1;
    check("glitch_no_frame", b_rx_cnt - base_rx, 0);
    check("glitch_rx_valid", b_rx_valid, 1'b0);

    // break: line low for 20 bit times
    base_rx = b_rx_cnt;
    push_exp(1, 8'h00, 1'b0, 1'b1);
    b_rx_drv = 1'b0;
    repeat (20 * C) @(posedge clk);
    #1;
    check("break_one_frame", b_rx_cnt - base_rx, 1);
    b_rx_drv = 1'b1;
    repeat (3 * C) @(posedge clk);
    #1;
    check("break_no_rearm", b_rx_cnt - base_rx, 1);
    check("break_rx_valid", b_rx_valid, 1'b0);

    // reset in the middle of data bit 3, then a clean frame
    b_use_wire = 1'b1;
    b_tx_data = 8'hC3;
    b_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    b_tx_valid = 1'b0;
    repeat (4 * C + 5) @(posedge clk);
    #1;
    check("rst_mid_busy", b_tx_ready, 1'b0);
    check("rst_mid_line_low", b_tx, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tx", b_tx, 1'b1);
    check("rst_mid_tx_ready", b_tx_ready, 1'b1);
    check("rst_mid_rx_valid", b_rx_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    base_rx = b_rx_cnt;
    push_exp(1, 8'h81, 1'b0, 1'b0);
    b_tx_data = 8'h81;
    b_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    b_tx_valid = 1'b0;
    wait_drain(400);
    check("post_rst_rx_count", b_rx_cnt - base_rx, 1);

    repeat (C) @(posedge clk);
    #1;
    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    check("c_queue_empty", q_c.size(), 0);
    check("a_tx_pin_high_end", a_tx_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Parametrised full-duplex UART: one TX and one RX engine sharing a clock, with valid/ready handshakes on both byte interfaces. It generalises the fixed 8N1 uart_tx/uart_rx pair with configurable bit period, data width, parity, stop bits, error reporting, a one-entry RX holding register with overrun detection, and internal loopback. It sits between CPU-side peripheral logic and the board serial pins.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per serial bit (100 MHz / 9600 baud); must be >= 4
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tx_data  input  DATA_BITS  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX can accept; transfer on tx_valid && tx_ready at posedge clk
tx  output  1  serial out, idle high
rx  input  1  serial in, asynchronous
rx_data  output  DATA_BITS  received payload
rx_valid  output  1  rx_data and error flags valid; held until consumed
rx_ready  input  1  consumer accepts rx_data on rx_valid && rx_ready
rx_parity_err  output  1  parity mismatch on held frame (valid with rx_valid)
rx_frame_err  output  1  a stop bit sampled low on held frame (valid with rx_valid)
rx_overrun  output  1  one-cycle pulse: frame completed while rx_valid high; new frame dropped
loopback  input  1  1 = RX fed from internal TX bitstream, tx pin forced high

Behaviour:
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error outputs 0, both FSMs IDLE, synchroniser flops = 1. Reset mid-frame aborts immediately; tx returns high the cycle after rst is sampled.
- Frame: start(0), DATA_BITS LSB-first, optional parity bit, STOP_BITS stop(1). Frame length F = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Parity: even -> parity bit = XOR of data; odd -> inverted XOR.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE. Each bit held exactly CLKS_PER_BIT cycles, counted by a bit-period counter.
- TX handshake: tx_data is latched on accept; tx goes low the next cycle. tx_ready = 1 in IDLE and in the final cycle of the last stop bit, 0 otherwise. An accept in that final cycle starts the next start bit with no idle gap, so back-to-back frames are contiguous. tx_data changes after accept have no effect.
- RX input: 2-flop synchroniser on rx (or on the internal TX line when loopback=1). Switching loopback mid-frame is unsupported; the RX frame in progress may be corrupted.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronised line arms START.
  - START: resample at CLKS_PER_BIT/2. If high, the start bit is false: return to IDLE with no output.
  - Subsequent bits are sampled every CLKS_PER_BIT from that midpoint.
  - Frame completes at the mid-sample of the last stop bit. RX is back in IDLE the next cycle and can detect a start edge immediately.
- Frame completion with rx_valid=0 (or rx_valid && rx_ready in the same cycle): load rx_data and the error flags, and set rx_valid next cycle.
- Frame completion with rx_valid=1 and rx_ready=0: pulse rx_overrun for 1 cycle. Held data and flags are unchanged.
- rx_valid clears the cycle after rx_valid && rx_ready, unless a new frame loads in that same cycle.
- Break/line-low: if any stop bit samples 0, set frame_err and deliver the frame. RX then stays in IDLE until the synchronised line has been high for at least 1 cycle before it re-arms.
- Latency: rx_valid rises 3 cycles (2 sync + 1 register) after the mid-sample of the last stop bit on the line.

Test Plan:
- CLKS_PER_BIT=16, 8N1, loopback=1: send 0xAB, 0xFF, 0x00, 0x12 back-to-back with tx_valid held high -> each received in order with no errors; TX frame spacing exactly 160 cycles; tx pin stays 1 throughout.
- External wire tx->rx, PARITY=2, STOP_BITS=2: send 0x5A -> parity bit 0 on the wire, frame is 192 cycles, rx_data=0x5A, rx_parity_err=0. With PARITY=1 -> parity bit 1.
- Drive rx directly with 0x3C but a flipped parity bit (even parity) -> rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
- Hold rx_ready=0 and receive 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses exactly 1 cycle at the second frame's completion. Then assert rx_ready -> rx_valid falls the next cycle.
- Glitch rx low for 5 cycles (< CLKS_PER_BIT/2) -> no rx_valid. Hold rx low for 20 bit times -> one frame with rx_data=0x00 and rx_frame_err=1, no re-arm until rx returns high.
- Assert rst mid-TX during bit 3 -> tx=1 and tx_ready=1 the next cycle. A new send of 0x81 after reset is received correctly.
